car_warning_ctrl: RTL and testbench
===================================

// Module: car_warning_ctrl
// PURPOSE
//  Clocked, parametrised car warning controller. Debounces N_DOORS door switches, N_SEATS belt/occupancy
//  switches and Ignition, then drives a pulsed chime. Door-open chimes until the door is closed; the
//  unbuckled-belt chime mutes after CHIME_LIMIT chime periods. Sits between raw cabin switches and the chime driver.
// PARAMETERS
//  N_DOORS      4  number of door switches (>=1)
//  N_SEATS      2  number of seats with belt + occupancy switch (>=1)
//  DEB_CYCLES   4  consecutive differing samples needed to accept an input change (>=1)
//  CHIME_ON     8  cycles Alarm is high per chime period (>=1)
//  CHIME_OFF    8  cycles Alarm is low per chime period (>=1)
//  CHIME_LIMIT  3  belt-only chime periods before muting (>=1)
// PORTS
//  Clk           in   1        single clock, rising edge
//  Reset         in   1        synchronous, active-high
//  Ignition      in   1        raw, 1 = ignition on
//  DoorClose     in   N_DOORS  raw, 1 = door closed
//  SeatBelt      in   N_SEATS  raw, 1 = belt fastened
//  SeatOccupied  in   N_SEATS  raw, 1 = seat occupied
//  Alarm         out  1        chime drive, decoded from registered state (glitch-free)
//  DoorWarn      out  1        registered: IgnF & |~DoorF
//  BeltWarn      out  1        registered: IgnF & |(OccF & ~BeltF)
//  BeltMuted     out  1        registered: belt reminder silenced
// BEHAVIOUR
//  Reset (sync, active-high): filtered DoorClose = all 1; SeatBelt, SeatOccupied and Ignition = 0;
//   all counters 0; state IDLE; every output 0. Reset asserted mid-chime: Alarm 0 after that edge.
//   Inputs held through reset need a full DEB_CYCLES again.
//  Debounce (per bit): counter increments each edge raw != filtered and clears when raw == filtered.
//   Filtered takes raw on the DEB_CYCLES-th consecutive differing edge.
//  DoorWarn and BeltWarn are registered from the filtered values, so each asserts 1 edge after
//   its filtered input changes. The FSM leaves IDLE on that same edge.
//  Timer: down-counter, width $clog2(max(CHIME_ON,CHIME_OFF)+1).
//   Period count: width $clog2(CHIME_LIMIT+1), saturating.
//  FSM states: IDLE, CHIME_ON, CHIME_OFF, MUTED. Alarm = (state == CHIME_ON).
//   door = DoorWarn condition, belt = BeltWarn condition.
//   IDLE:      door|belt -> CHIME_ON; timer = CHIME_ON-1; period count = 0.
//   CHIME_ON:  timer==0 -> CHIME_OFF; timer = CHIME_OFF-1.
//   CHIME_OFF: at timer==0, period count +1 and:
//              - door -> CHIME_ON; period count cleared (door chime never mutes);
//              - else belt && count+1 == CHIME_LIMIT -> MUTED;
//              - else CHIME_ON.
//   MUTED:     door -> CHIME_ON (new period count); !belt -> IDLE.
//              BeltMuted = (state == MUTED).
//   Any state: !door && !belt -> IDLE on the next edge; Alarm 0 there.
//    This priority is highest, so ignition off mid-chime cuts the chime immediately.
//  Simultaneous events: door wins over mute.
//   Door and belt rising on the same edge -> one CHIME_ON, treated as a door chime.
// STRUCTURE
//  Package car_warning_pkg:
//   - state enum typedef (IDLE, CHIME_ON, CHIME_OFF, MUTED)
//   - default parameter constants
//  Sub-module input_debounce (parameters WIDTH, DEB_CYCLES): vector debouncer with reset value RST_VAL.
//   Three instances: doors, seats (belt + occupancy concatenated), ignition.
//  Top level holds the condition registers, timer, period counter and FSM.
// TESTING  (defaults: DEB 4, ON 8, OFF 8, LIMIT 3)
//  - Raw Ignition=1 and DoorClose=4'b1110 held through reset: all outputs 0 during reset.
//    After release, DoorWarn=1 and Alarm=1 on the 5th edge.
//  - Ignition on, DoorClose[2] low for 3 cycles then high: DoorWarn and Alarm never assert.
//  - Door 1 held open: Alarm 8 high / 8 low repeating for >=10 periods; BeltMuted stays 0.
//  - Seat 0 occupied and unbuckled, doors closed: exactly 3 chime periods, then BeltMuted=1 and Alarm=0.
//    Buckle: BeltMuted=0 and state IDLE 5 edges later.
//  - Muted, then door 3 opened: Alarm=1 on the edge DoorWarn rises; BeltMuted=0 on the same edge.
//  - Ignition dropped in CHIME_ON: Alarm=0 on the edge after filtered Ignition falls.
//    Reset asserted mid-CHIME_ON: Alarm=0 after that edge.

Source files
------------

// File: rtl/car_warning_pkg.sv
// Shared types and default parameter values for the car warning controller.
package car_warning_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHIME_ON  = 2'd1,
    ST_CHIME_OFF = 2'd2,
    ST_MUTED     = 2'd3
  } state_t;

  localparam int DEF_N_DOORS     = 4;
  localparam int DEF_N_SEATS     = 2;
  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_CHIME_ON    = 8;
  localparam int DEF_CHIME_OFF   = 8;
  localparam int DEF_CHIME_LIMIT = 3;

endpackage

// File: rtl/input_debounce.sv
// Per-bit debouncer: a bit's filtered value follows its raw value only after
// DEB_CYCLES consecutive edges on which the two differ.
module input_debounce #(
  parameter int               WIDTH      = 1,
  parameter int               DEB_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_filt
);

  localparam int             CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_filt;

  // NOTE: the counter array is only a few flops per bit, so it is reset like
  // ordinary registers; a held input must re-qualify from zero after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_filt <= RST_VAL;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i_raw[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LAST) begin
          r_filt[i] <= i_raw[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/car_warning_ctrl.sv
// Car warning controller: debounced door/belt/ignition switches drive a pulsed
// chime; door chimes never mute, belt-only chimes mute after CHIME_LIMIT periods.
module car_warning_ctrl
  import car_warning_pkg::*;
#(
  parameter int N_DOORS     = DEF_N_DOORS,
  parameter int N_SEATS     = DEF_N_SEATS,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int CHIME_ON    = DEF_CHIME_ON,
  parameter int CHIME_OFF   = DEF_CHIME_OFF,
  parameter int CHIME_LIMIT = DEF_CHIME_LIMIT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Ignition,
  input  logic [N_DOORS-1:0] DoorClose,
  input  logic [N_SEATS-1:0] SeatBelt,
  input  logic [N_SEATS-1:0] SeatOccupied,
  output logic               Alarm,
  output logic               DoorWarn,
  output logic               BeltWarn,
  output logic               BeltMuted
);

  localparam int TMAX = (CHIME_ON > CHIME_OFF) ? CHIME_ON : CHIME_OFF;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(CHIME_LIMIT + 1);
  localparam logic [TW-1:0] T_ON  = TW'(CHIME_ON - 1);
  localparam logic [TW-1:0] T_OFF = TW'(CHIME_OFF - 1);
  localparam logic [PW-1:0] P_LIM = PW'(CHIME_LIMIT);

  logic                 w_ign_f;
  logic [N_DOORS-1:0]   w_door_f;
  logic [N_SEATS-1:0]   w_belt_f;
  logic [N_SEATS-1:0]   w_occ_f;
  logic                 w_door;
  logic                 w_belt;
  logic [PW-1:0]        w_pcnt_inc;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [PW-1:0] r_pcnt;
  logic          r_alarm;
  logic          r_muted;
  logic          r_door_warn;
  logic          r_belt_warn;

  input_debounce #(.WIDTH(1), .DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_deb_ign (
    .Clk(Clk), .Reset(Reset), .i_raw(Ignition), .o_filt(w_ign_f)
  );

  input_debounce #(.WIDTH(N_DOORS), .DEB_CYCLES(DEB_CYCLES), .RST_VAL({N_DOORS{1'b1}})) u_deb_door (
    .Clk(Clk), .Reset(Reset), .i_raw(DoorClose), .o_filt(w_door_f)
  );

  input_debounce #(.WIDTH(2*N_SEATS), .DEB_CYCLES(DEB_CYCLES), .RST_VAL('0)) u_deb_seat (
    .Clk(Clk), .Reset(Reset), .i_raw({SeatOccupied, SeatBelt}), .o_filt({w_occ_f, w_belt_f})
  );

  assign w_door     = w_ign_f & ~(&w_door_f);
  assign w_belt     = w_ign_f & (|(w_occ_f & ~w_belt_f));
  assign w_pcnt_inc = (r_pcnt == P_LIM) ? r_pcnt : r_pcnt + 1'b1;

  // Alarm and BeltMuted are registered alongside the state so they never glitch.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_pcnt      <= '0;
      r_alarm     <= 1'b0;
      r_muted     <= 1'b0;
      r_door_warn <= 1'b0;
      r_belt_warn <= 1'b0;
    end else begin
      r_door_warn <= w_door;
      r_belt_warn <= w_belt;
      r_alarm     <= 1'b0;
      r_muted     <= 1'b0;
      if (!w_door && !w_belt) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_CHIME_ON;
            r_timer <= T_ON;
            r_pcnt  <= '0;
            r_alarm <= 1'b1;
          end
          ST_CHIME_ON: begin
            if (r_timer == '0) begin
              r_state <= ST_CHIME_OFF;
              r_timer <= T_OFF;
            end else begin
              r_timer <= r_timer - 1'b1;
              r_alarm <= 1'b1;
            end
          end
          ST_CHIME_OFF: begin
            if (r_timer != '0) begin
              r_timer <= r_timer - 1'b1;
            end else if (w_door) begin
              r_state <= ST_CHIME_ON;
              r_timer <= T_ON;
              r_pcnt  <= '0;
              r_alarm <= 1'b1;
            end else if (w_pcnt_inc == P_LIM) begin
              r_state <= ST_MUTED;
              r_pcnt  <= w_pcnt_inc;
              r_muted <= 1'b1;
            end else begin
              r_state <= ST_CHIME_ON;
              r_timer <= T_ON;
              r_pcnt  <= w_pcnt_inc;
              r_alarm <= 1'b1;
            end
          end
          default: begin
            // Reaching here means belt or door is active; door restarts chiming.
            if (w_door) begin
              r_state <= ST_CHIME_ON;
              r_timer <= T_ON;
              r_pcnt  <= '0;
              r_alarm <= 1'b1;
            end else begin
              r_muted <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign Alarm     = r_alarm;
  assign BeltMuted = r_muted;
  assign DoorWarn  = r_door_warn;
  assign BeltWarn  = r_belt_warn;

endmodule

// File: tb/tb_car_warning_ctrl.sv
// Scenario bench for car_warning_ctrl: expected output values are queued with
// the cycle they are due on and compared at the falling edge of that cycle.
module tb_car_warning_ctrl;

  logic       clk = 1'b0;
  logic       Reset;
  logic       Ignition;
  logic [3:0] DoorClose;
  logic [1:0] SeatBelt;
  logic [1:0] SeatOccupied;
  logic       Alarm, DoorWarn, BeltWarn, BeltMuted;

  car_warning_ctrl dut (
    .Clk(clk), .Reset(Reset), .Ignition(Ignition), .DoorClose(DoorClose),
    .SeatBelt(SeatBelt), .SeatOccupied(SeatOccupied),
    .Alarm(Alarm), .DoorWarn(DoorWarn), .BeltWarn(BeltWarn), .BeltMuted(BeltMuted)
  );

  always #5 clk = ~clk;

  typedef enum {F_ALARM, F_DW, F_BW, F_MUTED} fld_t;
  typedef struct {
    int unsigned cyc;
    fld_t        fld;
    logic        val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic observe(input fld_t f);
    case (f)
      F_ALARM: return Alarm;
      F_DW:    return DoorWarn;
      F_BW:    return BeltWarn;
      default: return BeltMuted;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].tag, observe(sb[i].fld), sb[i].val);
        sb.delete(i);
      end
    end
  end

  // Queue an expectation k edges after the current drive point.
  task automatic expect_at(input int k, input fld_t f, input logic v, input string tag);
    exp_t e;
    e.cyc = cyc + k;
    e.fld = f;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_all(input int k, input logic a, input logic dw, input logic bw,
                            input logic m, input string tag);
    expect_at(k, F_ALARM, a,  {tag, "_alarm"});
    expect_at(k, F_DW,    dw, {tag, "_dw"});
    expect_at(k, F_BW,    bw, {tag, "_bw"});
    expect_at(k, F_MUTED, m,  {tag, "_muted"});
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic settle();
    DoorClose    = 4'b1111;
    SeatBelt     = 2'b00;
    SeatOccupied = 2'b00;
    expect_all(5, 1'b0, 1'b0, 1'b0, 1'b0, "settle");
    run(6);
  endtask

  initial begin
    Reset        = 1'b1;
    Ignition     = 1'b1;
    DoorClose    = 4'b1110;
    SeatBelt     = 2'b00;
    SeatOccupied = 2'b00;
    @(negedge clk);
    #1;

    // Inputs held through reset: outputs stay low, then a full debounce after release.
    for (int k = 1; k <= 3; k++) expect_all(k, 1'b0, 1'b0, 1'b0, 1'b0, "rst_hold");
    run(3);
    Reset = 1'b0;
    expect_all(4, 1'b0, 1'b0, 1'b0, 1'b0, "rel_e4");
    expect_at(5, F_DW,    1'b1, "rel_dw_e5");
    expect_at(5, F_ALARM, 1'b1, "rel_alarm_e5");
    run(6);
    DoorClose = 4'b1111;
    expect_at(4, F_ALARM, 1'b1, "close_alarm_e4");
    expect_at(5, F_ALARM, 1'b0, "close_alarm_e5");
    expect_at(5, F_DW,    1'b0, "close_dw_e5");
    run(6);

    // Three-cycle door glitch must be rejected.
    DoorClose = 4'b1011;
    for (int k = 1; k <= 10; k++) begin
      expect_at(k, F_DW,    1'b0, "glitch_dw");
      expect_at(k, F_ALARM, 1'b0, "glitch_alarm");
    end
    run(3);
    DoorClose = 4'b1111;
    run(7);

    // Door 1 held open: 8 on / 8 off for ten periods, never muted.
    DoorClose = 4'b1101;
    expect_at(5, F_DW, 1'b1, "door_dw");
    for (int p = 0; p < 10; p++) begin
      for (int j = 0; j < 16; j++)
        expect_at(5 + 16*p + j, F_ALARM, (j < 8), "door_period");
      expect_at(5 + 16*p + 15, F_MUTED, 1'b0, "door_nomute");
    end
    run(5 + 160);
    settle();

    // Belt-only: three chime periods then muted.
    SeatOccupied = 2'b01;
    expect_at(5, F_BW, 1'b1, "belt_bw");
    for (int j = 0; j < 48; j++)
      expect_at(5 + j, F_ALARM, ((j % 16) < 8), "belt_period");
    expect_at(52, F_MUTED, 1'b0, "belt_premute");
    expect_at(53, F_MUTED, 1'b1, "belt_muted");
    for (int k = 53; k <= 60; k++) expect_at(k, F_ALARM, 1'b0, "muted_alarm");
    run(60);
    SeatBelt = 2'b01;
    expect_at(4, F_MUTED, 1'b1, "buckle_muted_e4");
    expect_at(4, F_BW,    1'b1, "buckle_bw_e4");
    expect_all(5, 1'b0, 1'b0, 1'b0, 1'b0, "buckle_e5");
    run(6);

    // Muted again, then door 3 opens: chime restarts and mute clears together.
    SeatBelt = 2'b00;
    expect_at(53, F_MUTED, 1'b1, "remute");
    run(56);
    DoorClose = 4'b0111;
    expect_all(4, 1'b0, 1'b0, 1'b1, 1'b1, "door3_e4");
    expect_all(5, 1'b1, 1'b1, 1'b1, 1'b0, "door3_e5");
    run(6);
    settle();

    // Ignition dropped mid CHIME_ON cuts the chime.
    DoorClose = 4'b1110;
    expect_at(5, F_ALARM, 1'b1, "ign_chime_e5");
    run(6);
    Ignition = 1'b0;
    expect_at(4, F_ALARM, 1'b1, "ignoff_alarm_e4");
    expect_at(5, F_ALARM, 1'b0, "ignoff_alarm_e5");
    expect_at(5, F_DW,    1'b0, "ignoff_dw_e5");
    run(6);

    // Reset mid CHIME_ON, then inputs re-qualify from scratch.
    Ignition = 1'b1;
    expect_at(5, F_ALARM, 1'b1, "ignon_alarm_e5");
    run(7);
    Reset = 1'b1;
    expect_all(1, 1'b0, 1'b0, 1'b0, 1'b0, "midrst_e1");
    expect_all(2, 1'b0, 1'b0, 1'b0, 1'b0, "midrst_e2");
    run(3);
    Reset = 1'b0;
    expect_at(4, F_ALARM, 1'b0, "postrst_alarm_e4");
    expect_at(5, F_ALARM, 1'b1, "postrst_alarm_e5");
    expect_at(5, F_DW,    1'b1, "postrst_dw_e5");
    run(6);

    run(2);
    while (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s never compared (due cyc=%0d)", sb[0].tag, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
